// File: rtl/shift_left_pipe.sv
// Pipelined left shifter / normaliser: decode stage plus one stage per shift bit.
// Define SHL_OVF_EN to add the out_ovf port (OR of every bit shifted out).
module shift_left_pipe #(
    parameter int WIDTH = 25,
    parameter int TAG_W = 8,
    localparam int SHW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_norm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero,
`ifdef SHL_OVF_EN
    output logic             out_ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int NS = SHW + 1;

    logic [NS-1:0]      v_q;
    logic [NS-1:0]      vin;
    logic [NS-1:0]      rdy;
    logic [WIDTH-1:0]   data_q [NS];
    logic [WIDTH-1:0]   data_d [NS];
    logic [SHW-1:0]     s_q    [NS];
    logic [SHW-1:0]     s_d    [NS];
    logic [TAG_W-1:0]   tag_q  [NS];
    logic [TAG_W-1:0]   tag_d  [NS];
    logic               zero_q;
    logic               zero_d;
    logic [2*WIDTH-1:0] wide;
`ifdef SHL_OVF_EN
    logic [NS-1:0]      ovf_q;
    logic [NS-1:0]      ovf_d;
`endif

    function automatic logic [SHW-1:0] lzc(input logic [WIDTH-1:0] d);
        logic [SHW-1:0] n;
        n = SHW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) n = SHW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    // A stage can load if it, or any stage after it, is empty, or the sink drains.
    for (genvar k = 0; k < NS; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~(&v_q[NS-1:k]);
    end

    always_comb begin
        vin       = {v_q[NS-2:0], in_valid};
        wide      = '0;
        data_d[0] = in_data;
        s_d[0]    = in_norm ? lzc(in_data) : in_shift;
        tag_d[0]  = in_tag;
`ifdef SHL_OVF_EN
        ovf_d[0]  = 1'b0;
`endif
        for (int k = 1; k < NS; k++) begin
            // Upper half of the widened word collects the bits pushed out.
            wide = {{WIDTH{1'b0}}, data_q[k-1]}
                   << (s_q[k-1][SHW-k] ? (1 << (SHW - k)) : 0);
            data_d[k] = wide[WIDTH-1:0];
            s_d[k]    = s_q[k-1];
            tag_d[k]  = tag_q[k-1];
`ifdef SHL_OVF_EN
            ovf_d[k]  = ovf_q[k-1] | (|wide[2*WIDTH-1:WIDTH]);
`endif
        end
        zero_d = (data_d[NS-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            zero_q <= 1'b0;
`ifdef SHL_OVF_EN
            ovf_q  <= '0;
`endif
            for (int k = 0; k < NS; k++) begin
                data_q[k] <= '0;
                s_q[k]    <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= vin[k];
                    if (vin[k]) begin
                        data_q[k] <= data_d[k];
                        s_q[k]    <= s_d[k];
                        tag_q[k]  <= tag_d[k];
`ifdef SHL_OVF_EN
                        ovf_q[k]  <= ovf_d[k];
`endif
                    end
                end
            end
            if (rdy[NS-1] && vin[NS-1]) zero_q <= zero_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NS-1];
    assign out_data  = data_q[NS-1];
    assign out_shift = s_q[NS-1];
    assign out_tag   = tag_q[NS-1];
    assign out_zero  = zero_q;
`ifdef SHL_OVF_EN
    assign out_ovf   = ovf_q[NS-1];
`endif

endmodule

// File: tb/tb_shift_left_pipe.sv
// Self-checking bench for shift_left_pipe: directed cases, random singles,
// a stalled random stream against a queue-based reference, and mid-flight reset.
module tb_shift_left_pipe;

    localparam int W     = 25;
    localparam int TAG_W = 8;
    localparam int SHW   = $clog2(W + 1);
    localparam int NS    = SHW + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [SHW-1:0]   in_shift;
    logic             in_norm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [SHW-1:0]   out_shift;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;
    logic             ovf_obs;
`ifdef SHL_OVF_EN
    logic             out_ovf;
    assign ovf_obs = out_ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0]     d;
        logic [SHW-1:0]   s;
        logic             z;
        logic             o;
        logic [TAG_W-1:0] t;
    } exp_t;

    always #5 clk = ~clk;

    shift_left_pipe #(.WIDTH(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_norm   (in_norm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero),
`ifdef SHL_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_tag   (out_tag)
    );

    // Reference: shift amount from the rules, then shift in 64-bit arithmetic.
    function automatic exp_t model(input logic [W-1:0] d, input logic [SHW-1:0] sh,
                                   input logic norm, input logic [TAG_W-1:0] t);
        exp_t e;
        int n;
        longint full;
        if (norm) begin
            n = 0;
            while (n < W && d[W-1-n] == 1'b0) n++;
        end else begin
            n = int'(sh);
        end
        full = longint'(d) << n;
        e.d = W'(full);
        e.s = SHW'(n);
        e.z = (e.d == '0);
`ifdef SHL_OVF_EN
        e.o = ((full >> W) != 0);
`else
        e.o = 1'b0;
`endif
        e.t = t;
        return e;
    endfunction

    // Drives one transaction into an idle pipe and captures the first result.
    task automatic send1(input logic [W-1:0] d, input logic [SHW-1:0] sh,
                         input logic norm, input logic [TAG_W-1:0] t,
                         output int lat, output exp_t got);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = sh;
        in_norm   = norm;
        in_tag    = t;
        out_ready = 1'b1;
        @(posedge clk);
        lat = -1;
        got = '{default: '0};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat   = c;
                got.d = out_data;
                got.s = out_shift;
                got.z = out_zero;
                got.o = ovf_obs;
                got.t = out_tag;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_norm   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({out_data, out_shift, out_tag, out_zero, ovf_obs} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got d=%h s=%0d t=%h z=%b o=%b expected all 0",
                     out_data, out_shift, out_tag, out_zero, ovf_obs);
        end
    endtask

    task automatic test_normalise;
        int lat;
        exp_t g;
        send1(25'h0000123, '0, 1'b1, 8'h5A, lat, g);
        n_checks++;
        if (lat !== NS) begin
            n_fail++; $display("FAIL norm_latency: got %0d expected %0d", lat, NS);
        end
        n_checks++;
        if (g.d !== 25'h1230000) begin
            n_fail++; $display("FAIL norm_data: got %h expected 1230000", g.d);
        end
        n_checks++;
        if (g.s !== SHW'(16)) begin
            n_fail++; $display("FAIL norm_shift: got %0d expected 16", g.s);
        end
        n_checks++;
        if (g.z !== 1'b0 || g.o !== 1'b0 || g.t !== 8'h5A) begin
            n_fail++; $display("FAIL norm_flags: got z=%b o=%b t=%h expected 0 0 5a",
                               g.z, g.o, g.t);
        end
    endtask

    task automatic test_norm_zero;
        int lat;
        exp_t g;
        send1('0, SHW'(3), 1'b1, 8'h11, lat, g);
        n_checks++;
        if (lat !== NS) begin
            n_fail++; $display("FAIL nz_latency: got %0d expected %0d", lat, NS);
        end
        n_checks++;
        if (g.d !== '0 || g.s !== SHW'(W)) begin
            n_fail++; $display("FAIL nz_result: got d=%h s=%0d expected 0 %0d", g.d, g.s, W);
        end
        n_checks++;
        if (g.z !== 1'b1 || g.o !== 1'b0) begin
            n_fail++; $display("FAIL nz_flags: got z=%b o=%b expected 1 0", g.z, g.o);
        end
    endtask

    task automatic test_explicit;
        int lat;
        exp_t g;
        logic ovf_on;
`ifdef SHL_OVF_EN
        ovf_on = 1'b1;
`else
        ovf_on = 1'b0;
`endif
        send1(25'h1FFFFFF, SHW'(4), 1'b0, 8'h21, lat, g);
        n_checks++;
        if (lat !== NS || g.d !== 25'h1FFFFF0 || g.s !== SHW'(4)) begin
            n_fail++; $display("FAIL exp4: got lat=%0d d=%h s=%0d expected %0d 1fffff0 4",
                               lat, g.d, g.s, NS);
        end
        n_checks++;
        if (g.o !== ovf_on || g.z !== 1'b0 || g.t !== 8'h21) begin
            n_fail++; $display("FAIL exp4_flags: got o=%b z=%b t=%h expected %b 0 21",
                               g.o, g.z, g.t, ovf_on);
        end
        send1(25'h1FFFFFF, SHW'(0), 1'b0, 8'h22, lat, g);
        n_checks++;
        if (g.d !== 25'h1FFFFFF || g.s !== '0 || g.o !== 1'b0) begin
            n_fail++; $display("FAIL exp0: got d=%h s=%0d o=%b expected 1ffffff 0 0",
                               g.d, g.s, g.o);
        end
        send1(25'h0000001, SHW'(31), 1'b0, 8'h23, lat, g);
        n_checks++;
        if (g.d !== '0 || g.s !== SHW'(31) || g.z !== 1'b1) begin
            n_fail++; $display("FAIL exp31: got d=%h s=%0d z=%b expected 0 31 1",
                               g.d, g.s, g.z);
        end
        n_checks++;
        if (g.o !== ovf_on) begin
            n_fail++; $display("FAIL exp31_ovf: got %b expected %b", g.o, ovf_on);
        end
    endtask

    task automatic test_random;
        int lat;
        exp_t g, e;
        logic [W-1:0] d;
        logic [SHW-1:0] sh;
        logic nm;
        for (int i = 0; i < 10; i++) begin
            d  = W'($urandom) & W'((64'd1 << $urandom_range(0, W)) - 1);
            sh = SHW'($urandom_range(0, 31));
            nm = 1'($urandom_range(0, 1));
            e  = model(d, sh, nm, TAG_W'(i + 8'h40));
            send1(d, sh, nm, TAG_W'(i + 8'h40), lat, g);
            n_checks++;
            if (lat !== NS || g !== e) begin
                n_fail++;
                $display("FAIL rand_%0d: got lat=%0d d=%h s=%0d z=%b o=%b t=%h expected lat=%0d d=%h s=%0d z=%b o=%b t=%h",
                         i, lat, g.d, g.s, g.z, g.o, g.t, NS, e.d, e.s, e.z, e.o, e.t);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int got  = 0;
        int occ  = 0;
        bit pend = 0;
        bit ix, ox;
        localparam int N = 24;
        for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && sent < N && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
                if ($urandom_range(0, 1) == 1) in_data = in_data >> $urandom_range(0, W);
                in_shift = SHW'($urandom_range(0, 31));
                in_norm  = 1'($urandom_range(0, 1));
                in_tag   = TAG_W'(sent);
                pend     = 1;
            end else if (!pend) begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in_ready !== !(occ == NS && !out_ready)) begin
                n_fail++;
                $display("FAIL b2b_in_ready: got %b expected %b (occ=%0d out_ready=%b)",
                         in_ready, !(occ == NS && !out_ready), occ, out_ready);
            end
            ix = in_valid && in_ready;
            ox = out_valid && out_ready;
            if (ox) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got tag %h expected none", out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_shift !== e.s || out_zero !== e.z ||
                        ovf_obs !== e.o || out_tag !== e.t) begin
                        n_fail++;
                        $display("FAIL b2b_result: got d=%h s=%0d z=%b o=%b t=%h expected d=%h s=%0d z=%b o=%b t=%h",
                                 out_data, out_shift, out_zero, ovf_obs, out_tag,
                                 e.d, e.s, e.z, e.o, e.t);
                    end
                end
                got++;
            end
            if (ix) begin
                q.push_back(model(in_data, in_shift, in_norm, in_tag));
                sent++;
                pend = 0;
            end
            occ = occ + int'(ix) - int'(ox);
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== N || q.size() !== 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results (%0d pending) expected %0d",
                               got, q.size(), N);
        end
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = W'($urandom) | 25'h1;
            in_shift  = SHW'(i);
            in_norm   = 1'b0;
            in_tag    = TAG_W'(8'hA0 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: got out_valid=%b in_ready=%b expected 0 1",
                               out_valid, in_ready);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL rst_stale: got %0d stale results expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_normalise();
        test_norm_zero();
        test_explicit();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
